// File: rtl/coefficient_unit.sv
// Biquad low-pass (RBJ, Q = 1/sqrt(2)) coefficient generator using an iterative 16-step CORDIC.
// Optional macro W_CLAMP_EN saturates the input cutoff to pi/2 before the CORDIC.
module coefficient_unit #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int CORDIC_ITERS = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [SAMPLE_WIDTH-1:0] digital_cutoff_freq,
   output logic                    ready,
   output logic [SAMPLE_WIDTH-1:0] b0,
   output logic [SAMPLE_WIDTH-1:0] b1,
   output logic [SAMPLE_WIDTH-1:0] b2,
   output logic [SAMPLE_WIDTH-1:0] a0,
   output logic [SAMPLE_WIDTH-1:0] a1,
   output logic [SAMPLE_WIDTH-1:0] a2
);

   localparam int W  = SAMPLE_WIDTH;
   localparam int IW = (CORDIC_ITERS > 1) ? $clog2(CORDIC_ITERS) : 1;
   localparam int PW = 2 * W;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ROTATE = 2'd1;
   localparam logic [1:0] CALC   = 2'd2;

   function automatic logic signed [W-1:0] atan_lut(input int idx);
      case (idx)
         0:       atan_lut = W'(51472);
         1:       atan_lut = W'(30386);
         2:       atan_lut = W'(16055);
         3:       atan_lut = W'(8150);
         4:       atan_lut = W'(4091);
         5:       atan_lut = W'(2047);
         6:       atan_lut = W'(1024);
         7:       atan_lut = W'(512);
         8:       atan_lut = W'(256);
         9:       atan_lut = W'(128);
         10:      atan_lut = W'(64);
         11:      atan_lut = W'(32);
         12:      atan_lut = W'(16);
         13:      atan_lut = W'(8);
         14:      atan_lut = W'(4);
         15:      atan_lut = W'(2);
         default: atan_lut = '0;
      endcase
   endfunction

   function automatic logic [W-1:0] clamp_w(input logic [W-1:0] wv);
`ifdef W_CLAMP_EN
      clamp_w = (wv > W'(102944)) ? W'(102944) : wv;
`else
      clamp_w = wv;
`endif
   endfunction

   function automatic logic signed [W-1:0] trunc_w(input logic signed [31:0] v);
      trunc_w = W'(v);
   endfunction

   logic [1:0]            state;
   logic [IW-1:0]         iter;
   logic signed [W-1:0]   x, y, z;
   logic signed [W-1:0]   x_sh, y_sh, ang;
   logic signed [W-1:0]   x_nx, y_nx, z_nx;

   always_comb begin
      x_sh = x >>> iter;
      y_sh = y >>> iter;
      ang  = atan_lut(int'(iter));
      x_nx = x;
      y_nx = y;
      z_nx = z;
      // Rotate towards z = 0; a non-negative residual angle rotates counter-clockwise.
      if (!z[W-1]) begin
         x_nx = x - y_sh;
         y_nx = y + x_sh;
         z_nx = z - ang;
      end else begin
         x_nx = x + y_sh;
         y_nx = y - x_sh;
         z_nx = z + ang;
      end
   end

   logic signed [31:0]   c32, alpha32;
   logic signed [PW-1:0] s_ext, prod;
   logic signed [31:0]   b0_32, b1_32, a0_32, a1_32, a2_32;

   always_comb begin
      c32     = {{(32-W){x[W-1]}}, x};
      s_ext   = {{(PW-W){y[W-1]}}, y};
      prod    = s_ext * PW'(46341);
      alpha32 = 32'(prod >>> 16);
      b1_32   = 32'sd65536 - c32;
      b0_32   = b1_32 >>> 1;
      a0_32   = 32'sd65536 + alpha32;
      a1_32   = -(c32 <<< 1);
      a2_32   = 32'sd65536 - alpha32;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         iter  <= '0;
         x     <= '0;
         y     <= '0;
         z     <= '0;
         ready <= 1'b0;
         b0    <= '0;
         b1    <= '0;
         b2    <= '0;
         a0    <= '0;
         a1    <= '0;
         a2    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x     <= W'(39797);
                  y     <= '0;
                  z     <= clamp_w(digital_cutoff_freq);
                  iter  <= '0;
                  ready <= 1'b0;
                  state <= ROTATE;
               end
            end
            // ---- CORDIC iterations ----
            ROTATE: begin
               x    <= x_nx;
               y    <= y_nx;
               z    <= z_nx;
               iter <= iter + 1'b1;
               if (iter == IW'(CORDIC_ITERS - 1))
                  state <= CALC;
            end
            // ---- coefficient register stage ----
            CALC: begin
               b0    <= trunc_w(b0_32);
               b1    <= trunc_w(b1_32);
               b2    <= trunc_w(b0_32);
               a0    <= trunc_w(a0_32);
               a1    <= trunc_w(a1_32);
               a2    <= trunc_w(a2_32);
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coefficient_unit.sv
// Self-checking bench for coefficient_unit: cycle-by-cycle comparison against an arithmetic
// model, plus literal expectations for the documented cutoff points.
module tb_coefficient_unit;

   typedef struct {
      longint b0, b1, b2, a0, a1, a2;
   } coefs_t;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [23:0] w;
   logic        ready;
   logic [23:0] b0, b1, b2, a0, a1, a2;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 1'b0;

   always #5 clk = ~clk;

   coefficient_unit dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .digital_cutoff_freq (w),
      .ready               (ready),
      .b0                  (b0),
      .b1                  (b1),
      .b2                  (b2),
      .a0                  (a0),
      .a1                  (a1),
      .a2                  (a2)
   );

   function automatic longint sx(input logic [23:0] v);
      logic signed [23:0] t;
      t = v;
      return longint'(t);
   endfunction

   function automatic longint wrap24(input longint v);
      logic signed [23:0] t;
      t = v[23:0];
      return longint'(t);
   endfunction

   // Reference: sine/cosine by the documented CORDIC recurrence, then the cookbook formulas.
   function automatic coefs_t model(input int wv);
      int     atan_t [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                              256, 128, 64, 32, 16, 8, 4, 2};
      longint x, y, z, nx, ny, alpha;
      coefs_t r;
      z = wv;
`ifdef W_CLAMP_EN
      if (z > 102944) z = 102944;
`endif
      x = 39797;
      y = 0;
      for (int i = 0; i < 16; i++) begin
         if (z >= 0) begin
            nx = x - (y >>> i); ny = y + (x >>> i); z = z - atan_t[i];
         end else begin
            nx = x + (y >>> i); ny = y - (x >>> i); z = z + atan_t[i];
         end
         x = nx;
         y = ny;
      end
      alpha = (y * 46341) >>> 16;
      r.b1 = wrap24(65536 - x);
      r.b0 = wrap24((65536 - x) >>> 1);
      r.b2 = r.b0;
      r.a0 = wrap24(65536 + alpha);
      r.a1 = wrap24(-(x * 2));
      r.a2 = wrap24(65536 - alpha);
      return r;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_near(input string name, input longint act, input longint exp);
      n_checks++;
      if (act > exp + 8 || act < exp - 8) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d +/-8", name, act, exp);
      end
   endtask

   task automatic check_true(input string name, input bit cond, input longint prev, input longint cur);
      n_checks++;
      if (!cond) begin
         n_fail++;
         $display("FAIL %s: previous %0d, current %0d", name, prev, cur);
      end
   endtask

   task automatic check_set(input string tag, input coefs_t g, input longint eb0, input longint eb1,
                            input longint ea0, input longint ea1, input longint ea2);
      check_near({tag, " b0"}, g.b0, eb0);
      check_near({tag, " b1"}, g.b1, eb1);
      check_near({tag, " b2"}, g.b2, eb0);
      check_near({tag, " a0"}, g.a0, ea0);
      check_near({tag, " a1"}, g.a1, ea1);
      check_near({tag, " a2"}, g.a2, ea2);
   endtask

   // Expected behaviour: a start accepted while idle yields ready and new values 17 edges later.
   coefs_t exp_c, pend;
   logic   exp_ready;
   int     busy = 0;

   always @(posedge clk) begin
      if (reset) begin
         exp_ready = 1'b0;
         exp_c     = '{default: 0};
         busy      = 0;
      end else if (busy == 0) begin
         if (start) begin
            pend      = model(int'(w));
            busy      = 17;
            exp_ready = 1'b0;
         end
      end else begin
         busy--;
         if (busy == 0) begin
            exp_ready = 1'b1;
            exp_c     = pend;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("ready", longint'(ready), longint'(exp_ready));
         check("b0", sx(b0), exp_c.b0);
         check("b1", sx(b1), exp_c.b1);
         check("b2", sx(b2), exp_c.b2);
         check("a0", sx(a0), exp_c.a0);
         check("a1", sx(a1), exp_c.a1);
         check("a2", sx(a2), exp_c.a2);
      end
   end

   function automatic coefs_t grab();
      coefs_t g;
      g.b0 = sx(b0); g.b1 = sx(b1); g.b2 = sx(b2);
      g.a0 = sx(a0); g.a1 = sx(a1); g.a2 = sx(a2);
      return g;
   endfunction

   task automatic run(input int wv, output coefs_t got, output int lat);
      @(negedge clk);
      w     = 24'(wv);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (ready !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      got = grab();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      coefs_t g, prev, m;
      int     lat, n;
      int     freqs [11] = '{69, 500, 1024, 2024, 3024, 4024, 5024, 6024, 7024, 8024, 9024};

      reset = 1'b1;
      start = 1'b0;
      w     = '0;
      @(posedge clk);
      cmp_on = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("reset ready", longint'(ready), 0);
      check("reset b0", sx(b0), 0);
      check("reset b1", sx(b1), 0);
      check("reset a0", sx(a0), 0);
      check("reset a1", sx(a1), 0);
      check("reset a2", sx(a2), 0);
      reset = 1'b0;

      // Pin the reference model to the documented values.
      m = model(4289);
      check_set("model 1k", m, 70, 140, 68567, -130791, 62505);
      m = model(34315);
      check_set("model 8k", m, 4390, 8780, 88707, -113512, 42366);

      run(4289, g, lat);
      check("latency 1k", lat, 17);
      check_set("1k", g, 70, 140, 68567, -130791, 62505);

      run(34315, g, lat);
      check("latency 8k", lat, 17);
      check_set("8k", g, 4390, 8780, 88707, -113512, 42366);

      run(0, g, lat);
      check("latency w0", lat, 17);
      check_set("w0", g, 0, 0, 65536, -131072, 65536);

      // A second start while busy must not restart or redirect the computation.
      @(negedge clk);
      w     = 24'd4289;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      while (ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 5) begin
            w     = 24'd34315;
            start = 1'b1;
         end else if (n == 6) begin
            start = 1'b0;
         end
      end
      check("latency ignore", n, 17);
      g = grab();
      check_set("ignore", g, 70, 140, 68567, -130791, 62505);

      // Reset part-way through a computation.
      @(negedge clk);
      w     = 24'd34315;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort ready", longint'(ready), 0);
      check("abort b1", sx(b1), 0);
      check("abort a0", sx(a0), 0);

      for (int k = 0; k < 11; k++) begin
         run($rtoi(freqs[k] * 6.283185307179586 * 65536.0 / 96000.0 + 0.5), g, lat);
         check("latency sweep", lat, 17);
         if (k > 0) begin
            check_true("sweep b1 rising", g.b1 > prev.b1, prev.b1, g.b1);
            check_true("sweep a0 rising", g.a0 > prev.a0, prev.a0, g.a0);
            check_true("sweep |a1| falling", -g.a1 < -prev.a1, prev.a1, g.a1);
            check_true("sweep a2 falling", g.a2 < prev.a2, prev.a2, g.a2);
         end
         prev = g;
      end

`ifdef W_CLAMP_EN
      run(102944, prev, lat);
      check_near("clamp ref a1", prev.a1, 0);
      check_near("clamp ref a0", prev.a0, 111877);
      run(200000, g, lat);
      check("clamp latency", lat, 17);
      check("clamp b1", g.b1, prev.b1);
      check("clamp a0", g.a0, prev.a0);
      check("clamp a1", g.a1, prev.a1);
      check("clamp a2", g.a2, prev.a2);
`endif

      repeat (3) @(negedge clk);
      cmp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
